axi_stream_extract_header: RTL



---
 rtl/axi_stream_extract_header_if.sv | 59 +++++
 rtl/axi_stream_extract_header.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header_if.sv
// Bundle of the strip-config, input-stream, payload and header channels of axi_stream_extract_header.
// err_out only exists when AXIS_STRIP_ERR_CHK_EN is defined.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD = 32
) ();
  localparam int DATA_BYTE_WD = DATA_WD / 8;

  logic                    valid_strip;
  logic [DATA_BYTE_WD-1:0] keep_strip;
  logic                    ready_strip;

  logic                    valid_in;
  logic                    ready_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;

  logic                    valid_out;
  logic                    ready_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;

  logic                    valid_header;
  logic                    ready_header;
  logic [DATA_WD-1:0]      header_out;
  logic [DATA_BYTE_WD-1:0] header_keep_out;
`ifdef AXIS_STRIP_ERR_CHK_EN
  logic                    err_out;
`endif

  modport slave (
    input  valid_strip, keep_strip,
    output ready_strip,
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out,
    output valid_header, header_out, header_keep_out,
    input  ready_header
`ifdef AXIS_STRIP_ERR_CHK_EN
    , output err_out
`endif
  );

  modport master (
    output valid_strip, keep_strip,
    input  ready_strip,
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out,
    input  valid_header, header_out, header_keep_out,
    output ready_header
`ifdef AXIS_STRIP_ERR_CHK_EN
    , input err_out
`endif
  );
endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips an N-byte header from the first beat of each packet and re-packs the payload MSB-first.
// Optional AXIS_STRIP_ERR_CHK_EN adds a sticky err_out flag for illegal keep masks.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_stream_extract_header_if.slave bus
);
  localparam int NW = $clog2(DATA_BYTE_WD + 1);
  localparam int SW = $clog2(DATA_WD + 1);
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

  typedef enum logic [2:0] {IDLE, FIRST, BODY, FLUSH, DONE} state_t;

  state_t                  state_q;
  logic [NW-1:0]           n_q;
  logic [NW-1:0]           flush_cnt_q;
  logic [DATA_BYTE_WD-1:0] strip_keep_q;
  logic [DATA_WD-1:0]      res_q;
  logic                    valid_out_q;
  logic [DATA_WD-1:0]      data_out_q;
  logic [DATA_BYTE_WD-1:0] keep_out_q;
  logic                    last_out_q;
  logic                    valid_header_q;
  logic [DATA_WD-1:0]      header_out_q;
  logic [DATA_BYTE_WD-1:0] header_keep_out_q;

  function automatic logic [NW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] m);
    logic [NW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + NW'(m[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] top_ones(input logic [NW-1:0] k);
    return ~(KEEP_ALL >> k);
  endfunction

  // Bytes outside keep_in are zeroed so partial beats never leak stale data.
  logic [DATA_WD-1:0] data_m;
  for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_mask
    assign data_m[8*gi +: 8] = bus.keep_in[gi] ? bus.data_in[8*gi +: 8] : 8'h00;
  end

  logic [NW-1:0] v_in;
  logic [SW-1:0] res_shift;
  logic [SW-1:0] hdr_shift;
  logic          ready_strip_d;
  logic          ready_in_d;
  logic          strip_fire;
  logic          in_fire;
  logic          out_free;
  logic          hdr_free;

  assign v_in       = popcnt(bus.keep_in);
  assign res_shift  = SW'(n_q) << 3;
  assign hdr_shift  = SW'(DATA_WD) - res_shift;
  assign out_free   = !valid_out_q || bus.ready_out;
  assign hdr_free   = !valid_header_q || bus.ready_header;
  assign strip_fire = bus.valid_strip && ready_strip_d;
  assign in_fire    = bus.valid_in && ready_in_d;

  always_comb begin
    ready_strip_d = (state_q == IDLE) && !valid_header_q;
    ready_in_d    = 1'b0;
    case (state_q)
      FIRST:   ready_in_d = !valid_header_q && !valid_out_q;
      BODY:    ready_in_d = out_free;
      default: ready_in_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      n_q               <= '0;
      flush_cnt_q       <= '0;
      strip_keep_q      <= '0;
      res_q             <= '0;
      valid_out_q       <= 1'b0;
      data_out_q        <= '0;
      keep_out_q        <= '0;
      last_out_q        <= 1'b0;
      valid_header_q    <= 1'b0;
      header_out_q      <= '0;
      header_keep_out_q <= '0;
    end else begin
      if (valid_out_q && bus.ready_out)       valid_out_q    <= 1'b0;
      if (valid_header_q && bus.ready_header) valid_header_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (strip_fire) begin
            strip_keep_q <= bus.keep_strip;
            n_q          <= popcnt(bus.keep_strip);
            state_q      <= FIRST;
          end
        end
        FIRST: begin
          if (in_fire) begin
            header_out_q      <= bus.data_in >> hdr_shift;
            header_keep_out_q <= strip_keep_q;
            valid_header_q    <= 1'b1;
            res_q             <= data_m << res_shift;
            if (!bus.last_in) begin
              state_q <= BODY;
            end else begin
              valid_out_q <= 1'b1;
              last_out_q  <= 1'b1;
              if (v_in > n_q) begin
                data_out_q <= data_m << res_shift;
                keep_out_q <= top_ones(v_in - n_q);
              end else begin
                data_out_q <= '0;
                keep_out_q <= '0;
              end
              state_q <= DONE;
            end
          end
        end
        BODY: begin
          if (in_fire) begin
            valid_out_q <= 1'b1;
            data_out_q  <= res_q | (data_m >> hdr_shift);
            res_q       <= data_m << res_shift;
            keep_out_q  <= KEEP_ALL;
            last_out_q  <= 1'b0;
            if (bus.last_in) begin
              // Residual bytes fit into this beat only when the last beat is no wider than the header.
              if (v_in <= n_q) begin
                keep_out_q <= top_ones(NW'(DATA_BYTE_WD) - n_q + v_in);
                last_out_q <= 1'b1;
                state_q    <= DONE;
              end else begin
                flush_cnt_q <= v_in - n_q;
                state_q     <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            valid_out_q <= 1'b1;
            data_out_q  <= res_q;
            keep_out_q  <= top_ones(flush_cnt_q);
            last_out_q  <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_free && hdr_free) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_strip     = ready_strip_d;
  assign bus.ready_in        = ready_in_d;
  assign bus.valid_out       = valid_out_q;
  assign bus.data_out        = data_out_q;
  assign bus.keep_out        = keep_out_q;
  assign bus.last_out        = last_out_q;
  assign bus.valid_header    = valid_header_q;
  assign bus.header_out      = header_out_q;
  assign bus.header_keep_out = header_keep_out_q;

`ifdef AXIS_STRIP_ERR_CHK_EN
  function automatic logic lsb_contig(input logic [DATA_BYTE_WD-1:0] m);
    return (m & (m + DATA_BYTE_WD'(1))) == '0;
  endfunction

  logic err_q;
  logic err_d;

  always_comb begin
    err_d = 1'b0;
    if (strip_fire && !lsb_contig(bus.keep_strip)) err_d = 1'b1;
    if (in_fire && !bus.last_in && (bus.keep_in != KEEP_ALL)) err_d = 1'b1;
    if (in_fire && bus.last_in && ((bus.keep_in == '0) || !lsb_contig(~bus.keep_in))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (err_d) err_q <= 1'b1;
  end

  assign bus.err_out = err_q;
`endif
endmodule
